muldiv_seq: RTL

Iterative sequencer for the RV32M multiply/divide instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), attached beside the ALU in the EX stage. It accepts one operation from EX, stalls the pipeline while it iterates over WIDTH cycles, and then presents a single-cycle `done` with the 32-bit result for writeback. It is a shared multi-cycle resource with a start/busy/done handshake and a flush abort. It does not modify ALU control.

---
 rtl/muldiv_seq_pkg.sv | 41 ++++
 rtl/muldiv_seq_if.sv | 33 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared constants and types for the RV32M iterative multiply/divide sequencer.
//   MD_*   : funct3 encodings of the M-extension operations
//   MDS_*  : sequencer FSM states (md_state_t)
//   helper functions classifying an operation from its funct3
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_t;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is interpreted as two's complement.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    // rs2 is interpreted as two's complement (MULHSU keeps rs2 unsigned).
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// EX-stage <-> multiply/divide sequencer bundle.
//   start, funct3, op_a, op_b, kill : driven by EX (master)
//   stall, busy, done, result       : driven by the sequencer (slave)
// Handshake: an operation is taken on a rising edge where the sequencer is
// idle, start = 1 and kill = 0. While working, stall/busy stay high; the answer
// is signalled by a single-cycle done with result valid in that same cycle.
// kill drops any operation in flight without a done.
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             kill;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, kill,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, kill,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the shared multiply/divide datapath.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo  : working registers (multiply: {hi[W-1:0], lo} is the product with
//             the unconsumed multiplier bits in lo; divide: hi = partial
//             remainder, lo = dividend bits shifting out / quotient shifting in)
//   opnd    : multiplicand (multiply) or divisor (divide) magnitude
//   hi_next, lo_next : register values after this step
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        sum     = '0;
        shifted = '0;
        fits    = 1'b0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Bring the next dividend bit into the remainder and try a subtract.
            shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
            fits    = (shifted >= {1'b0, opnd});
            hi_next = fits ? (shifted - {1'b0, opnd}) : shifted;
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            // Add the multiplicand when the current multiplier bit is set, then
            // shift the whole 2W product right; the carry lands in the top bit.
            sum     = hi + (lo[0] ? {1'b0, opnd} : '0);
            hi_next = {1'b0, sum[WIDTH:1]};
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative RV32M multiply/divide sequencer sitting beside the ALU in EX.
// Takes one operation, freezes the front of the pipeline for WIDTH iterations
// plus one sign-fix cycle, then pulses done with the registered result.
// Divide-by-zero and signed overflow bypass the iteration (latency 1).
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : muldiv_seq_if slave (start/funct3/op_a/op_b/kill in,
//               stall/busy/done/result out)
//   state_dbg : current FSM state
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus,
    output md_state_t   state_dbg
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [2:0]       f3_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    // Accept-time decode of the incoming operation.
    logic             in_div;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             fast_hit;
    logic [WIDTH-1:0] fast_val;

    assign in_div = is_div_op(bus.funct3);
    assign sa     = a_is_signed(bus.funct3) & bus.op_a[WIDTH-1];
    assign sb     = b_is_signed(bus.funct3) & bus.op_b[WIDTH-1];
    assign a_mag  = sa ? -bus.op_a : bus.op_a;
    assign b_mag  = sb ? -bus.op_b : bus.op_b;

    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (in_div) begin
            if (bus.op_b == '0) begin
                // funct3[1] distinguishes REM* from DIV*.
                fast_hit = 1'b1;
                fast_val = bus.funct3[1] ? bus.op_a : '1;
            end else if (((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM)) &&
                         (bus.op_a == MIN_NEG) && (bus.op_b == '1)) begin
                fast_hit = 1'b1;
                fast_val = (bus.funct3 == MD_DIV) ? MIN_NEG : '0;
            end
        end
    end

    // Iteration datapath.
    logic [WIDTH:0]   hi_next;
    logic [WIDTH-1:0] lo_next;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (f3_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .opnd    (opnd_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign correction and output select used in the FIX cycle. The sign flags
    // are only ever set for the operations that need them, so unsigned ops and
    // MUL pass through untouched.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_val;

    assign prod     = {hi_q[WIDTH-1:0], lo_q};
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    assign rem_fix  = sign_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];

    always_comb begin
        case (f3_q)
            MD_MUL:                       fix_val = prod_fix[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              fix_val = quot_fix;
            default:                      fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MDS_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.kill) begin
                state <= MDS_IDLE;
            end else begin
                case (state)
                    MDS_IDLE: begin
                        if (bus.start) begin
                            f3_q     <= bus.funct3;
                            sign_a_q <= sa;
                            sign_b_q <= sb;
                            cnt      <= '0;
                            if (fast_hit) begin
                                result_q <= fast_val;
                                done_q   <= 1'b1;
                                state    <= MDS_DONE;
                            end else begin
                                // Multiply shifts the multiplier out of lo;
                                // divide shifts the dividend out of lo.
                                hi_q   <= '0;
                                lo_q   <= in_div ? a_mag : b_mag;
                                opnd_q <= in_div ? b_mag : a_mag;
                                state  <= MDS_CALC;
                            end
                        end
                    end
                    MDS_CALC: begin
                        hi_q <= hi_next;
                        lo_q <= lo_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= MDS_FIX;
                        end
                    end
                    MDS_FIX: begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        state    <= MDS_DONE;
                    end
                    default: begin
                        state <= MDS_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.stall  = rst_n & ((bus.start & ~bus.kill & (state == MDS_IDLE)) |
                                 (state == MDS_CALC) | (state == MDS_FIX));
    assign bus.busy   = (state != MDS_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign state_dbg  = state;
endmodule
